// File: rtl/cache_mem_arbiter.sv
// Two-port line-fill arbiter between the L1 I/D caches and the single memory bus.
// Round-robin by default; define CACHE_ARB_DPRIO_EN to give port 1 (D-cache) fixed priority.
module cache_mem_arbiter #(
    parameter int ADDRW = 64,
    parameter int TAGW  = 13,
    parameter int DATAW = 64,
    parameter int BEATS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c0_reqcyc,
    input  logic [ADDRW-1:0] c0_req,
    input  logic [TAGW-1:0]  c0_reqtag,
    output logic             c0_reqack,
    output logic             c0_respcyc,
    output logic [DATAW-1:0] c0_resp,
    output logic [TAGW-1:0]  c0_resptag,
    input  logic             c0_respack,
    input  logic             c1_reqcyc,
    input  logic [ADDRW-1:0] c1_req,
    input  logic [TAGW-1:0]  c1_reqtag,
    output logic             c1_reqack,
    output logic             c1_respcyc,
    output logic [DATAW-1:0] c1_resp,
    output logic [TAGW-1:0]  c1_resptag,
    input  logic             c1_respack,
    output logic             bus_reqcyc,
    output logic [ADDRW-1:0] bus_req,
    output logic [TAGW-1:0]  bus_reqtag,
    input  logic             bus_reqack,
    input  logic             bus_respcyc,
    input  logic [DATAW-1:0] bus_resp,
    input  logic [TAGW-1:0]  bus_resptag,
    output logic             bus_respack
);

    localparam int CNTW = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } stateT;

    stateT           stateR;
    stateT           stateNext;
    logic [CNTW-1:0] beatCntR;
    logic            gntR;
    logic            ptrR;
    logic            anyReq;
    logic            pickSel;
    logic            steerOn;
    logic            beatTake;
    logic            lastBeat;
    logic            grantRespack;
    logic            drainDone;

    // Arbitration pick and burst-progress qualifiers
    always_comb begin
        anyReq = c0_reqcyc | c1_reqcyc;
        if (c0_reqcyc && c1_reqcyc) begin
`ifdef CACHE_ARB_DPRIO_EN
            pickSel = 1'b1;
`else
            pickSel = ptrR;
`endif
        end else if (c1_reqcyc) begin
            pickSel = 1'b1;
        end else begin
            pickSel = 1'b0;
        end
        // A beat arriving together with the request accept already belongs to this burst
        steerOn      = (stateR == RESP) || (stateR == DRAIN) || ((stateR == ISSUE) && bus_reqack);
        beatTake     = steerOn && bus_respcyc && (stateR != DRAIN);
        lastBeat     = beatTake && (beatCntR == CNTW'(BEATS - 1));
        grantRespack = gntR ? c1_respack : c0_respack;
        drainDone    = !bus_respcyc && !grantRespack;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            stateR <= IDLE;
        end else begin
            stateR <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = stateR;
        case (stateR)
            IDLE:    stateNext = anyReq ? ISSUE : IDLE;
            ISSUE: begin
                if (bus_reqack) begin
                    stateNext = lastBeat ? DRAIN : RESP;
                end else begin
                    stateNext = ISSUE;
                end
            end
            RESP:    stateNext = lastBeat ? DRAIN : RESP;
            DRAIN:   stateNext = drainDone ? IDLE : DRAIN;
            default: stateNext = IDLE;
        endcase
    end

    // Grant, request latch, accept pulse, beat counter and priority pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            gntR       <= 1'b0;
            ptrR       <= 1'b0;
            beatCntR   <= '0;
            c0_reqack  <= 1'b0;
            c1_reqack  <= 1'b0;
            bus_reqcyc <= 1'b0;
            bus_req    <= '0;
            bus_reqtag <= '0;
        end else begin
            c0_reqack <= 1'b0;
            c1_reqack <= 1'b0;
            if (beatTake) begin
                beatCntR <= beatCntR + CNTW'(1);
            end
            case (stateR)
                IDLE: begin
                    if (anyReq) begin
                        gntR       <= pickSel;
                        bus_reqcyc <= 1'b1;
                        bus_req    <= pickSel ? c1_req : c0_req;
                        bus_reqtag <= pickSel ? c1_reqtag : c0_reqtag;
                        c0_reqack  <= !pickSel;
                        c1_reqack  <= pickSel;
                    end
                end
                ISSUE: begin
                    if (bus_reqack) begin
                        bus_reqcyc <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (drainDone) begin
                        beatCntR <= '0;
                        ptrR     <= ~ptrR;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Response steering towards the granted cache only
    always_comb begin
        c0_respcyc  = 1'b0;
        c0_resp     = '0;
        c0_resptag  = '0;
        c1_respcyc  = 1'b0;
        c1_resp     = '0;
        c1_resptag  = '0;
        bus_respack = 1'b0;
        if (steerOn) begin
            if (gntR) begin
                c1_respcyc = bus_respcyc;
                c1_resp    = bus_resp;
                c1_resptag = bus_resptag;
            end else begin
                c0_respcyc = bus_respcyc;
                c0_resp    = bus_resp;
                c0_resptag = bus_resptag;
            end
            bus_respack = grantRespack;
        end else begin
            bus_respack = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed + randomized bench for cache_mem_arbiter; reference model tracks grant order,
// pending requests and expected steering from the arbitration rules.
module tb_cache_mem_arbiter;

    localparam int ADDRW = 64;
    localparam int TAGW  = 13;
    localparam int DATAW = 64;
    localparam int BEATS = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             c0_reqcyc, c0_reqack, c0_respcyc, c0_respack;
    logic [ADDRW-1:0] c0_req;
    logic [TAGW-1:0]  c0_reqtag, c0_resptag;
    logic [DATAW-1:0] c0_resp;
    logic             c1_reqcyc, c1_reqack, c1_respcyc, c1_respack;
    logic [ADDRW-1:0] c1_req;
    logic [TAGW-1:0]  c1_reqtag, c1_resptag;
    logic [DATAW-1:0] c1_resp;
    logic             bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    logic [ADDRW-1:0] bus_req;
    logic [TAGW-1:0]  bus_reqtag, bus_resptag;
    logic [DATAW-1:0] bus_resp;

    cache_mem_arbiter #(.ADDRW(ADDRW), .TAGW(TAGW), .DATAW(DATAW), .BEATS(BEATS)) dut (
        .clk(clk), .reset(reset),
        .c0_reqcyc(c0_reqcyc), .c0_req(c0_req), .c0_reqtag(c0_reqtag), .c0_reqack(c0_reqack),
        .c0_respcyc(c0_respcyc), .c0_resp(c0_resp), .c0_resptag(c0_resptag), .c0_respack(c0_respack),
        .c1_reqcyc(c1_reqcyc), .c1_req(c1_req), .c1_reqtag(c1_reqtag), .c1_reqack(c1_reqack),
        .c1_respcyc(c1_respcyc), .c1_resp(c1_resp), .c1_resptag(c1_resptag), .c1_respack(c1_respack),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack)
    );

    int               vecs = 0;
    int               errs = 0;
    bit               tbPtr = 1'b0;
    bit               pend0 = 1'b0;
    bit               pend1 = 1'b0;
    logic [ADDRW-1:0] q0 = '0;
    logic [ADDRW-1:0] q1 = '0;
    logic [TAGW-1:0]  t0 = '0;
    logic [TAGW-1:0]  t1 = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drvReq();
        c0_reqcyc = pend0; c0_req = q0; c0_reqtag = t0;
        c1_reqcyc = pend1; c1_req = q1; c1_reqtag = t1;
    endtask

    task automatic newReq(input int p);
        if (p == 0 && !pend0) begin
            pend0 = 1'b1; q0 = {$urandom, $urandom}; t0 = TAGW'($urandom);
        end else if (p == 1 && !pend1) begin
            pend1 = 1'b1; q1 = {$urandom, $urandom}; t1 = TAGW'($urandom);
        end
    endtask

    // Drive one bus beat plus random cache acks; returns the ack the winner gave
    task automatic drvBeat(input int w, input bit rc, input logic [63:0] d, input logic [TAGW-1:0] tg,
                           output bit ra);
        bus_respcyc = rc; bus_resp = d; bus_resptag = tg;
        c0_respack = 1'($urandom); c1_respack = 1'($urandom);
        ra = (w == 1) ? c1_respack : c0_respack;
    endtask

    task automatic chkSteer(input string tag, input int w, input bit rc, input logic [63:0] d,
                            input logic [TAGW-1:0] tg, input bit ra);
        chk({tag, "_respcyc"}, {c1_respcyc, c0_respcyc}, (w == 1) ? {rc, 1'b0} : {1'b0, rc});
        chk({tag, "_resp"}, (w == 1) ? c1_resp : c0_resp, d);
        chk({tag, "_resptag"}, (w == 1) ? c1_resptag : c0_resptag, tg);
        chk({tag, "_other"}, (w == 1) ? {c0_resp, c0_resptag} : {c1_resp, c1_resptag}, 64'd0);
        chk({tag, "_respack"}, bus_respack, ra);
    endtask

    task automatic chkQuiet(input string tag);
        chk({tag, "_respcyc"}, {c1_respcyc, c0_respcyc}, 64'd0);
        chk({tag, "_resp"}, c0_resp | c1_resp, 64'd0);
        chk({tag, "_respack"}, bus_respack, 64'd0);
    endtask

    // One complete transaction; mode 0 = contiguous beats A0.., 1 = gapped pattern, 2 = random
    task automatic txn(input int ackDly, input int mode, input bit linger, input bit extra,
                       input logic [1:0] preNext, input int abortAt);
        int               w;
        int               beats;
        int               cyc;
        bit               rc;
        bit               ra;
        logic [ADDRW-1:0] ea;
        logic [TAGW-1:0]  et;
        logic [63:0]      d;
        logic [TAGW-1:0]  tg;
        logic [31:0]      gapMask;
        gapMask = 32'h0000_1D9A;
`ifdef CACHE_ARB_DPRIO_EN
        w = pend1 ? 1 : 0;
`else
        w = (pend0 && pend1) ? int'(tbPtr) : (pend1 ? 1 : 0);
`endif
        ea = (w == 1) ? q1 : q0;
        et = (w == 1) ? t1 : t0;
        drvReq();
        bus_reqack = 1'b0;
        drvBeat(w, 1'b1, {$urandom, $urandom}, TAGW'($urandom), ra);
        c0_respack = 1'b1; c1_respack = 1'b1;
        #1;
        chk("idle_reqack", {c1_reqack, c0_reqack}, 64'd0);
        chk("idle_busreqcyc", bus_reqcyc, 64'd0);
        chkQuiet("idle_stray");
        tick();
        if (w == 1) pend1 = 1'b0; else pend0 = 1'b0;
        drvReq();
        rc = 1'b0;
        for (int j = 0; j <= ackDly; j++) begin
            bus_reqack = (j == ackDly);
            rc = (j == ackDly) ? ((mode == 2) && ($urandom_range(0, 1) == 1)) : 1'($urandom);
            d = {$urandom, $urandom}; tg = TAGW'($urandom);
            drvBeat(w, rc, d, tg, ra);
            #1;
            chk("issue_reqack", {c1_reqack, c0_reqack}, (j == 0) ? ((w == 1) ? 64'd2 : 64'd1) : 64'd0);
            chk("issue_busreqcyc", bus_reqcyc, 64'd1);
            chk("issue_busreq", bus_req, ea);
            chk("issue_busreqtag", bus_reqtag, et);
            if (j < ackDly) chkQuiet("issue_stray");
            else if (rc) chkSteer("ack_beat", w, rc, d, tg, ra);
            else chk("ack_nobeat", {c1_respcyc, c0_respcyc}, 64'd0);
            tick();
        end
        bus_reqack = 1'b0;
        beats = rc ? 1 : 0;
        cyc = 1;
        while (beats < BEATS) begin
            if (abortAt != 0 && beats == abortAt) begin
                reset = 1'b1;
                drvBeat(w, 1'b1, {$urandom, $urandom}, TAGW'($urandom), ra);
                tick();
                reset = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    drvBeat(w, 1'b1, {$urandom, $urandom}, TAGW'($urandom), ra);
                    c0_respack = 1'b1; c1_respack = 1'b1;
                    #1;
                    chkQuiet("rst_stray");
                    chk("rst_reqack", {c1_reqack, c0_reqack}, 64'd0);
                    chk("rst_busreq", {bus_reqcyc, bus_req[50:0], bus_reqtag}, 64'd0);
                    tick();
                end
                tbPtr = 1'b0;
                return;
            end
            case (mode)
                0:       rc = 1'b1;
                1:       rc = gapMask[cyc];
                default: rc = ($urandom_range(0, 2) != 0);
            endcase
            d  = (mode == 0) ? (64'hA0 + 64'(beats)) : {$urandom, $urandom};
            tg = TAGW'($urandom);
            drvBeat(w, rc, d, tg, ra);
            #1;
            chkSteer("beat", w, rc, d, tg, ra);
            chk("resp_busreqcyc", bus_reqcyc, 64'd0);
            tick();
            if (rc) beats++;
            cyc++;
        end
        if (preNext[0]) newReq(0);
        if (preNext[1]) newReq(1);
        drvReq();
        if (extra) begin
            d = {$urandom, $urandom}; tg = TAGW'($urandom);
            drvBeat(w, 1'b1, d, tg, ra);
            #1;
            chkSteer("drain_extra", w, 1'b1, d, tg, ra);
            tick();
        end
        if (linger) begin
            d = {$urandom, $urandom}; tg = TAGW'($urandom);
            drvBeat(w, 1'b0, d, tg, ra);
            if (w == 1) c1_respack = 1'b1; else c0_respack = 1'b1;
            #1;
            chkSteer("drain_linger", w, 1'b0, d, tg, 1'b1);
            tick();
        end
        d = {$urandom, $urandom}; tg = TAGW'($urandom);
        drvBeat(w, 1'b0, d, tg, ra);
        if (w == 1) begin c1_respack = 1'b0; c0_respack = 1'b1; end
        else begin c0_respack = 1'b0; c1_respack = 1'b1; end
        #1;
        chkSteer("drain_exit", w, 1'b0, d, tg, 1'b0);
        chk("drain_reqack", {c1_reqack, c0_reqack}, 64'd0);
        tick();
        tbPtr = ~tbPtr;
    endtask

    initial begin
        reset = 1'b1;
        c0_reqcyc = 1'b0; c0_req = '0; c0_reqtag = '0; c0_respack = 1'b0;
        c1_reqcyc = 1'b0; c1_req = '0; c1_reqtag = '0; c1_respack = 1'b0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
        tick();
        tick();
        #1;
        chk("rst_reqack", {c1_reqack, c0_reqack}, 64'd0);
        chk("rst_busreqcyc", bus_reqcyc, 64'd0);
        chk("rst_busreq", bus_req, 64'd0);
        chk("rst_busreqtag", bus_reqtag, 64'd0);
        chkQuiet("rst_out");
        reset = 1'b0;
        tick();

        // Simultaneous pairs: grants alternate between ports
        newReq(0); newReq(1);
        txn(0, 2, 1'b0, 1'b0, 2'b01, 0);
        txn(1, 2, 1'b0, 1'b0, 2'b10, 0);
        txn(0, 2, 1'b0, 1'b0, 2'b00, 0);
        txn(2, 2, 1'b0, 1'b0, 2'b00, 0);

        // Single port 0 fill, data A0..A7
        pend0 = 1'b1; q0 = 64'h1000; t0 = 13'd5;
        txn(0, 0, 1'b0, 1'b0, 2'b00, 0);

        // Late bus accept and gapped beats, then back-to-back port 0 with lingering ack
        newReq(0);
        txn(5, 1, 1'b0, 1'b1, 2'b01, 0);
        txn(0, 2, 1'b1, 1'b0, 2'b01, 0);
        txn(1, 0, 1'b1, 1'b1, 2'b00, 0);

        // Reset mid-burst of a port 1 fill, then pointer must be back on port 0
        newReq(1);
        txn(2, 0, 1'b0, 1'b0, 2'b00, 3);
        newReq(0); newReq(1);
        txn(0, 2, 1'b0, 1'b0, 2'b00, 0);
        txn(0, 2, 1'b0, 1'b0, 2'b00, 0);

        for (int n = 0; n < 12; n++) begin
            if (!pend0 && !pend1) begin
                case ($urandom_range(0, 2))
                    0:       newReq(0);
                    1:       newReq(1);
                    default: begin newReq(0); newReq(1); end
                endcase
            end
            txn($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom), 1'($urandom),
                2'($urandom), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Downstream neighbour of the L1 instruction and data caches.
- Takes line-fill requests from two cache ports (port 0 = I-cache, port 1 = D-cache) and serialises them onto the single memory-side bus.
- Steers the multi-beat burst response back to the granted cache.
- Only one transaction is outstanding at a time; the grant is held until the whole burst has drained.

Parameters:
ADDRW, 64, width of req address
TAGW, 13, width of reqtag/resptag
DATAW, 64, width of one response beat
BEATS, 8, response beats per transaction (cache line / DATAW)

Ports:
clk  in  1  clock (rising edge)
reset  in  1  synchronous, active-high reset
c0_reqcyc  in  1  port 0 request valid, held until c0_reqack seen
c0_req  in  ADDRW  port 0 request address
c0_reqtag  in  TAGW  port 0 request tag
c0_reqack  out  1  one-cycle accept pulse to port 0
c0_respcyc  out  1  response beat valid to port 0
c0_resp  out  DATAW  response data to port 0
c0_resptag  out  TAGW  response tag to port 0
c0_respack  in  1  port 0 response acknowledge
c1_*  same eight signals for port 1
bus_reqcyc  out  1  memory request valid, held until bus_reqack
bus_req  out  ADDRW  memory request address
bus_reqtag  out  TAGW  memory request tag
bus_reqack  in  1  memory accepts request
bus_respcyc  in  1  memory response beat valid (one beat per high cycle)
bus_resp  in  DATAW  memory response data
bus_resptag  in  TAGW  memory response tag
bus_respack  out  1  acknowledge to memory

Behaviour:
- Reset (sync, reset high at clk edge):
  - State goes to IDLE; beat counter = 0; priority pointer = port 0.
  - All outputs = 0: reqack, respcyc, resp, resptag, bus_reqcyc, bus_req, bus_reqtag, bus_respack.
  - Reset mid-burst abandons the transaction; remaining bus beats are ignored until the next grant.
- FSM states: IDLE, ISSUE, RESP, DRAIN.
- IDLE:
  - If any cN_reqcyc is high, grant per arbitration.
  - Latch the granted req/reqtag into bus_req/bus_reqtag and set bus_reqcyc=1.
  - Pulse the granted cN_reqack for exactly one cycle (the cycle after the grant decision).
  - Go to ISSUE.
  - The non-granted port gets no reqack; its request stays pending.
- Arbitration:
  - One requester: it wins.
  - Both requesting in the same cycle: the port named by the priority pointer wins.
  - The pointer flips to the other port when a transaction completes (round-robin).
- ISSUE:
  - Hold bus_reqcyc/bus_req/bus_reqtag stable until bus_reqack=1.
  - Then drop bus_reqcyc next cycle and go to RESP.
  - If bus_respcyc arrives in the same cycle as bus_reqack, that beat is counted and routed.
- RESP:
  - Combinational steering:
    - granted cN_respcyc = bus_respcyc.
    - granted cN_resp = bus_resp; granted cN_resptag = bus_resptag.
    - bus_respack = granted cN_respack.
  - Non-granted port sees respcyc=0 and resp/resptag=0.
  - Beat counter (width clog2(BEATS)+1) increments on each cycle with bus_respcyc=1.
  - When counter reaches BEATS, go to DRAIN.
- DRAIN:
  - Steering stays on the granted port until bus_respcyc=0 and cN_respack=0 (cache's trailing ack cleared).
  - Then clear the counter, flip the priority pointer, and return to IDLE.
  - First new grant comes earliest the cycle after.
- Minimum transaction latency, request to first reqack: 1 cycle.
- Boundaries:
  - bus_respcyc while in IDLE or ISSUE-before-ack is ignored (no port sees it).
  - Beats beyond BEATS while in DRAIN are still steered but not counted.
  - cN_reqcyc dropping before its ack: the request is still issued once granted (latched).

Optional Feature:
- Macro: CACHE_ARB_DPRIO_EN.
- Defined: fixed priority; port 1 (D-cache) always wins simultaneous requests and the pointer is unused.
- Undefined: round-robin as above.
- In both modes, a port that is already granted is never pre-empted.

Test Plan:
- Single port 0 request, req=0x1000, tag=5: c0_reqack pulses 1 cycle, bus_req=0x1000, bus_reqtag=5. Bus returns 8 beats 0xA0..0xA7: c0_resp sees them in order, c1_respcyc stays 0, state returns to IDLE.
- Both ports request in the same cycle after reset: port 0 granted first. Port 1 acked only after port 0's 8th beat and drain. Third simultaneous pair goes to port 0 again (pointer alternates). With CACHE_ARB_DPRIO_EN, port 1 wins every pair.
- bus_reqack delayed 5 cycles: bus_reqcyc and bus_req stay stable for all 5 cycles, then bus_reqcyc=0 the next cycle.
- bus_respcyc pulses with gaps (beats on cycles 1,3,4,7,8,10,11,12): exactly 8 beats routed, counter hits 8, DRAIN entered. A stray bus_respcyc in IDLE produces no cN_respcyc.
- Reset asserted after beat 3 of a port 1 burst: next cycle all outputs 0, state IDLE, pointer = port 0. A new port 0 request is then granted normally.
- Back-to-back port 0 requests with cN_respack lingering one cycle: the next grant does not happen until respack=0; no beat is lost or duplicated.
